tnn_img_unpacker: RTL



---
 rtl/tnn_img_unpacker.sv | 114 +++++++++++
 1 files changed

// File: rtl/tnn_img_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tnn_img_unpacker
// Brief    : 512-to-64 width-down converter and image framer feeding the TNN
//            pixel input. Emits lane 0 first and marks frame first/last words.
// Revision : 1.0 - initial release
// ============================================================================
module tnn_img_unpacker #(
    parameter int IN_W        = 512,
    parameter int OUT_W       = 64,
    parameter int RATIO       = IN_W / OUT_W,
    parameter int FRAME_WORDS = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IN_W-1:0]  s_bits,
    input  logic             s_vld,
    output logic             s_rdy,
    output logic [OUT_W-1:0] m_bits,
    output logic             m_vld,
    input  logic             m_rdy,
    output logic             m_first,
    output logic             m_last,
    output logic             busy,
    output logic [CNT_W-1:0] frames_done
);

    localparam int c_lane_w = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int c_wc_w   = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(RATIO - 1);
    localparam logic [c_wc_w-1:0]   c_last_word = c_wc_w'(FRAME_WORDS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IN_W-1:0]     r_hold;
    logic                r_full;
    logic [c_lane_w-1:0] r_lane;
    logic [c_wc_w-1:0]   r_word_cnt;
    logic [CNT_W-1:0]    r_frames_done;

    logic                w_in_acc;
    logic                w_out_acc;
    logic                w_lane_last;
    logic                w_word_last;
    logic [OUT_W-1:0]    w_lanes [RATIO];

    generate
        for (genvar k = 0; k < RATIO; k++) begin : g_lanes
            assign w_lanes[k] = r_hold[k*OUT_W +: OUT_W];
        end
    endgenerate

    assign w_lane_last = (r_lane == c_last_lane);
    assign w_word_last = (r_word_cnt == c_last_word);
    assign w_out_acc   = r_full & m_rdy;
    // A new beat may land in the same cycle the final lane drains, so the
    // stream never bubbles between beats.
    assign s_rdy       = ~reset & (~r_full | (w_out_acc & w_lane_last));
    assign w_in_acc    = s_vld & s_rdy;

    assign m_bits      = w_lanes[r_lane];
    assign m_vld       = r_full;
    assign m_first     = r_full & (r_word_cnt == '0);
    assign m_last      = r_full & w_word_last;
    assign busy        = (r_state == ST_RUN);
    assign frames_done = r_frames_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_full        <= 1'b0;
            r_lane        <= '0;
            r_word_cnt    <= '0;
            r_frames_done <= '0;
            r_state       <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
            if (w_in_acc) begin
                r_hold <= s_bits;
                r_full <= 1'b1;
                r_lane <= '0;
            end else if (w_out_acc) begin
                if (w_lane_last) begin
                    r_full <= 1'b0;
                    r_lane <= '0;
                end else begin
                    r_lane <= r_lane + 1'b1;
                end
            end
            if (w_out_acc) begin
                if (w_word_last) begin
                    r_word_cnt    <= '0;
                    r_frames_done <= r_frames_done + 1'b1;
                end else begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_out_acc) begin
            w_state_nxt = w_word_last ? ST_IDLE : ST_RUN;
        end
    end

endmodule
`default_nettype wire
